// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner and the blocks
// that build frames for it.
package seg_pkg;
   localparam int NUM_DIGITS = 8;
   localparam int SEG_W      = 8;
   localparam int IDX_W      = 3;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

   localparam int              DIV_DEF     = 100000;
   localparam int              BLANK_DEF   = 16;
   localparam logic [SEG_W-1:0] SEG_OFF_DEF = 8'h00;

   // Active-low one-hot select for digit i.
   function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [IDX_W-1:0] i);
      return ~(NUM_DIGITS'(1) << i);
   endfunction
endpackage

// File: rtl/seg_scan_if.sv
// Frame input and display drive of the segment scanner, plus scan-position
// debug taps.
interface seg_scan_if;
   import seg_pkg::*;

   // No valid/ready: seg_in/en_in are level inputs sampled once per frame at
   // the frame end; frame_tick pulses the cycle after that sample is taken.
   logic [NUM_DIGITS*SEG_W-1:0] seg_in;
   logic [NUM_DIGITS-1:0]       en_in;
   logic [SEG_W-1:0]            seg_out;
   logic [NUM_DIGITS-1:0]       an;
   logic                        frame_tick;
   logic [IDX_W-1:0]            dbg_idx;
   logic                        dbg_lit;

   modport master (
      output seg_in, en_in,
      input  seg_out, an, frame_tick, dbg_idx, dbg_lit
   );

   modport slave (
      input  seg_in, en_in,
      output seg_out, an, frame_tick, dbg_idx, dbg_lit
   );
endinterface

// File: rtl/scan_tick_gen.sv
// Slot timing for the scanner: cycle-in-slot counter and digit index, with
// the lit window and frame-end strobe derived from them.
module scan_tick_gen
   import seg_pkg::*;
#(
   parameter int DIV   = DIV_DEF,
   parameter int BLANK = BLANK_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             slot_lit_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             frame_end_o
);
   localparam int CW = $clog2(DIV);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wrap;

   assign wrap = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (wrap) begin
         cnt_d = '0;
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   // Signed compare keeps BLANK=0 from degenerating into an unsigned >= 0.
   assign slot_lit_o  = (int'(cnt_q) >= BLANK);
   assign idx_o       = idx_q;
   assign frame_end_o = wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed display driver: latches a frame at each frame end
// and scans it out one digit per slot with a leading blank window.
module seg_scan
   import seg_pkg::*;
#(
   parameter int               DIV     = DIV_DEF,
   parameter int               BLANK   = BLANK_DEF,
   parameter logic [SEG_W-1:0] SEG_OFF = SEG_OFF_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   seg_scan_if.slave  bus
);
   logic             slot_lit;
   logic [IDX_W-1:0] idx;
   logic             frame_end;

   logic [SEG_W-1:0]      shadow_seg_q [NUM_DIGITS];
   logic [SEG_W-1:0]      shadow_seg_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic                  tick_q, tick_d;

   scan_tick_gen #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) u_tick (
      .clk         (clk),
      .rst_n       (rst_n),
      .slot_lit_o  (slot_lit),
      .idx_o       (idx),
      .frame_end_o (frame_end)
   );

   // Outputs are computed from the pre-load shadow, so slot 0 of the next
   // frame is the first to see a freshly latched frame.
   always_comb begin
      shadow_seg_d = shadow_seg_q;
      shadow_en_d  = shadow_en_q;
      if (frame_end) begin
         for (int j = 0; j < NUM_DIGITS; j++) begin
            shadow_seg_d[j] = bus.seg_in[SEG_W*j +: SEG_W];
         end
         shadow_en_d = bus.en_in;
      end
   end

   always_comb begin
      an_d   = AN_OFF;
      seg_d  = SEG_OFF;
      tick_d = frame_end;
      if (shadow_en_q[idx] && slot_lit) begin
         an_d  = digit_sel(idx);
         seg_d = shadow_seg_q[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NUM_DIGITS; j++) begin
            shadow_seg_q[j] <= SEG_OFF;
         end
         shadow_en_q <= '0;
         an_q        <= AN_OFF;
         seg_q       <= SEG_OFF;
         tick_q      <= 1'b0;
      end else begin
         shadow_seg_q <= shadow_seg_d;
         shadow_en_q  <= shadow_en_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         tick_q       <= tick_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg_out    = seg_q;
   assign bus.frame_tick = tick_q;
   assign bus.dbg_idx    = idx;
   assign bus.dbg_lit    = slot_lit;
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (DIV=8/BLANK=2 and DIV=2/BLANK=0) checked
// every cycle against a cycle-count model, plus fixed-value scenario checks.
module tb_seg_scan;
   localparam int DIV_T[2]   = '{8, 2};
   localparam int BLANK_T[2] = '{2, 0};

   logic        clk;
   logic        rst_n;
   logic [63:0] seg_in;
   logic [7:0]  en_in;
   int          phase;

   int tests = 0;
   int fails = 0;

   seg_scan_if bus_a ();
   seg_scan_if bus_b ();

   assign bus_a.seg_in = seg_in;
   assign bus_a.en_in  = en_in;
   assign bus_b.seg_in = seg_in;
   assign bus_b.en_in  = en_in;

   seg_scan #(.DIV(8), .BLANK(2), .SEG_OFF(8'h00)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   seg_scan #(.DIV(2), .BLANK(0), .SEG_OFF(8'h00)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // n_q counts rising edges since reset release; position within a frame
   // is n mod 8*DIV, digit = pos / DIV, cycle-in-slot = pos mod DIV.
   int         n_q;
   logic [7:0] m_seg [2][8];
   logic [7:0] m_en  [2];
   logic [7:0] e_an  [2];
   logic [7:0] e_seg [2];
   logic       e_tick[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q <= 0;
         for (int k = 0; k < 2; k++) begin
            m_en[k]   <= 8'h00;
            e_an[k]   <= 8'hFF;
            e_seg[k]  <= 8'h00;
            e_tick[k] <= 1'b0;
            for (int j = 0; j < 8; j++) m_seg[k][j] <= 8'h00;
         end
      end else begin
         n_q <= n_q + 1;
         for (int k = 0; k < 2; k++) begin
            int fr, p, d, c;
            fr = 8 * DIV_T[k];
            p  = n_q % fr;
            d  = p / DIV_T[k];
            c  = p % DIV_T[k];
            if (m_en[k][d] && c >= BLANK_T[k]) begin
               e_an[k]  <= ~(8'b1 << d);
               e_seg[k] <= m_seg[k][d];
            end else begin
               e_an[k]  <= 8'hFF;
               e_seg[k] <= 8'h00;
            end
            e_tick[k] <= (p == fr - 1);
            if (p == fr - 1) begin
               m_en[k] <= en_in;
               for (int j = 0; j < 8; j++) m_seg[k][j] <= seg_in[8*j +: 8];
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", name, act, exp, n_q, $time);
      end
   endtask

   int lit_cnt[8];
   int prev_tick_b;

   always begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
         chk("rst_an_a",   32'(bus_a.an),         32'hFF);
         chk("rst_seg_a",  32'(bus_a.seg_out),    32'h00);
         chk("rst_tick_a", 32'(bus_a.frame_tick), 32'h0);
         chk("rst_an_b",   32'(bus_b.an),         32'hFF);
         chk("rst_tick_b", 32'(bus_b.frame_tick), 32'h0);
         prev_tick_b = -1;
      end else begin
         chk("an_a",   32'(bus_a.an),         32'(e_an[0]));
         chk("seg_a",  32'(bus_a.seg_out),    32'(e_seg[0]));
         chk("tick_a", 32'(bus_a.frame_tick), 32'(e_tick[0]));
         chk("an_b",   32'(bus_b.an),         32'(e_an[1]));
         chk("seg_b",  32'(bus_b.seg_out),    32'(e_seg[1]));
         chk("tick_b", 32'(bus_b.frame_tick), 32'(e_tick[1]));
         chk("idx_a",  32'(bus_a.dbg_idx),    32'((n_q % 64) / 8));
         chk("lit_a",  32'(bus_a.dbg_lit),    32'(((n_q % 64) % 8) >= 2));
         chk("onehot_a", 32'($countones(~bus_a.an) <= 1), 32'h1);
         chk("onehot_b", 32'($countones(~bus_b.an) <= 1), 32'h1);
         if (bus_b.frame_tick) begin
            if (prev_tick_b >= 0) chk("tick_period_b", 32'(n_q - prev_tick_b), 32'd16);
            prev_tick_b = n_q;
         end
         if (phase == 1 || phase == 4) begin
            if (n_q >= 1 && n_q <= 63) chk("first_frame_blank", 32'(bus_a.an), 32'hFF);
            if (n_q == 64) chk("first_tick_at_64", 32'(bus_a.frame_tick), 32'h1);
         end
         if (phase == 1) begin
            if (n_q == 90) chk("slot3_cnt1_blank", 32'(bus_a.an), 32'hFF);
            if (n_q == 91 || n_q == 96) begin
               chk("slot3_an",  32'(bus_a.an),      32'hF7);
               chk("slot3_seg", 32'(bus_a.seg_out), 32'hC0);
            end
            if (n_q == 97) chk("slot4_cnt0_blank", 32'(bus_a.an), 32'hFF);
         end
         if (phase == 2) begin
            if (n_q == 128) for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
            if (n_q >= 129 && n_q <= 192)
               for (int i = 0; i < 8; i++) if (bus_a.an == ~(8'b1 << i)) lit_cnt[i]++;
            if (n_q == 192)
               for (int i = 0; i < 8; i++) chk($sformatf("lit_cycles_d%0d", i), 32'(lit_cnt[i]), (i == 0) ? 32'd0 : 32'd6);
            if (n_q == 172) begin
               chk("d5_old_an",  32'(bus_a.an),      32'hDF);
               chk("d5_old_seg", 32'(bus_a.seg_out), 32'hA4);
            end
            if (n_q == 236) begin
               chk("d5_new_an",  32'(bus_a.an),      32'hDF);
               chk("d5_new_seg", 32'(bus_a.seg_out), 32'h99);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic wait_n(input int target);
      for (int g = 0; g < 4000 && n_q < target; g++) @(negedge clk);
   endtask

   initial begin
      phase  = 0;
      rst_n  = 1'b0;
      seg_in = {8{8'hC0}};
      en_in  = 8'hFF;
      repeat (3) @(negedge clk);
      phase = 1;
      rst_n = 1'b1;
      wait_n(100);

      // Steady frame with digit 0 disabled; digit 5 changes mid-frame.
      phase = 2;
      for (int j = 0; j < 8; j++) seg_in[8*j +: 8] = 8'($urandom_range(0, 255));
      seg_in[47:40] = 8'hA4;
      en_in = 8'hFE;
      wait_n(150);
      seg_in[47:40] = 8'h99;
      wait_n(240);

      phase = 3;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            for (int j = 0; j < 8; j++) seg_in[8*j +: 8] = 8'($urandom_range(0, 255));
            en_in = 8'($urandom_range(0, 255));
         end
      end

      // Mid-frame reset at digit 4, cycle 5 with all digits lit.
      seg_in = {8{8'h5A}};
      en_in  = 8'hFF;
      wait_n(n_q + 140);
      for (int g = 0; g < 64 && (n_q % 64) != 37; g++) @(negedge clk);
      #2;
      phase = 4;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_n(150);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range DIV >= 2.
REQ-002 Parameter BLANK, default 16: leading cycles of each slot with all digits off (ghost suppression); legal range 0 <= BLANK < DIV.
REQ-003 Parameter SEG_OFF, default 8'h00: segment pattern driven while no digit is lit.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 seg_in  input  64  frame of 8 segment patterns; digit i at bits [8i+7:8i], i = 0..7.
REQ-007 en_in  input  8  per-digit enable; bit i high = digit i displayed.
REQ-008 seg_out  output  8  segment pattern of the currently lit digit, registered.
REQ-009 an  output  8  digit select, active-low, at most one bit low, registered.
REQ-010 frame_tick  output  1  one-cycle pulse, registered; marks a new frame latched.

Function
REQ-011 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0; digit index idx SHALL advance 0..7 on each cnt wrap, then wrap 7->0.
REQ-012 Shadow registers (8x8 pattern, 8 enable bits) SHALL load seg_in/en_in only on the edge where idx==7 and cnt==DIV-1; the block SHALL hold seg_in/en_in stable through a frame; mid-frame input changes SHALL NOT be visible before the next frame.
REQ-013 frame_tick SHALL be high for exactly the one cycle following the shadow load edge; it SHALL be low at all other times.
REQ-014 Output register update each edge: if shadow_en[idx]==1 and cnt>=BLANK, an <= ~(8'b1<<idx) and seg_out <= shadow_seg[idx]; else an <= 8'hFF and seg_out <= SEG_OFF.
REQ-015 Output latency SHALL be one cycle: an/seg_out reflect the (idx,cnt) state of the previous cycle.
REQ-016 Disabled digits (en bit 0) SHALL produce an=8'hFF for their whole slot; slot timing SHALL NOT be skipped or compressed.
REQ-017 Frame period SHALL be exactly 8*DIV cycles; lit time per enabled digit SHALL be exactly DIV-BLANK cycles per frame.
REQ-018 Slot 0 of a frame SHALL use the shadow contents loaded on the preceding edge, including when BLANK=0.
REQ-019 Segment patterns SHALL pass through unmodified; no decoding, inversion or reordering.

Reset
REQ-020 While rst_n low: cnt=0, idx=0, all shadow patterns=SEG_OFF, shadow enables=8'h00, an=8'hFF, seg_out=SEG_OFF, frame_tick=0; outputs SHALL change immediately, without a clock.
REQ-021 After rst_n rises, the first frame (8*DIV cycles) SHALL be fully blank; inputs present at its final edge appear in frame 2.
REQ-022 Reset asserted mid-slot or mid-frame SHALL abandon the frame; no partial shadow load and no frame_tick.

Structure
REQ-023 Shared package seg_pkg SHALL hold NUM_DIGITS=8, SEG_W=8, AN_OFF=8'hFF, and the DIV/BLANK/SEG_OFF defaults, shared with the frame producers.
REQ-024 One sub-module scan_tick_gen SHALL contain the cnt/idx counters and expose slot_lit (cnt>=BLANK), idx and frame_end (idx==7 and cnt==DIV-1); shadow and output registers stay in seg_scan.

Verification (DIV=8, BLANK=2, SEG_OFF=8'h00)
REQ-025 Reset release, seg_in all 8'hC0, en_in=8'hFF -> cycles 0..63 an=8'hFF; frame_tick high at cycle 64; slot 3 of frame 2, cnt 2..7 (outputs 1 cycle later) -> an=8'hF7, seg_out=8'hC0.
REQ-026 en_in=8'hFE in steady state -> an=8'hFF for all of slot 0; slots 1..7 lit 6 of 8 cycles each.
REQ-027 Change seg_in digit 5 from 8'hA4 to 8'h99 at mid-frame -> slot 5 of current frame shows 8'hA4; next frame shows 8'h99.
REQ-028 rst_n low at idx=4, cnt=5 -> an=8'hFF, seg_out=8'h00 same cycle; no frame_tick; after release, 64 blank cycles again.
REQ-029 BLANK=0, DIV=2 -> every enabled digit lit both cycles of its slot; frame_tick period exactly 16 cycles; an never has two bits low.
